switch_io: RTL and testbench

- Input-side responder for the CPU's 24-bit switch bus: the CPU is the reader, this block is the read target.
- Synchronises and debounces the raw `switch_in[23:0]`, then holds a stable snapshot.
- Presents the snapshot through a small combinational read port on the CPU's IO space.
- Keeps a sticky change flag (clear-on-read) and a wrapping change counter, so software can poll for new mode/data values (mode in bits 23:21, data in bits 15:0).

---
 rtl/switch_io.sv | 112 +++++++++++
 tb/tb_switch_io.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_io.sv
// Switch bus read target: two-flop synchroniser, debounce window and stable
// snapshot, with a sticky clear-on-read change flag and a wrapping change counter.
module switch_io #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] switch_in,
  input  logic        io_rd,
  input  logic [1:0]  io_addr,
  output logic [31:0] io_rdata,
  output logic [2:0]  sw_mode,
  output logic        sw_changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  logic [23:0]   sync1_r;
  logic [23:0]   sync2_r;
  logic [23:0]   cand_r;
  logic [23:0]   stable_r;
  logic [CW-1:0] deb_cnt_r;
  logic          changed_r;
  logic [15:0]   chg_cnt_r;

  logic          load_s;
  logic          set_s;
  logic          clr_s;

  // Window completion, change detection and clear-on-read qualification
  always_comb begin
    load_s = 1'b0;
    set_s  = 1'b0;
    clr_s  = 1'b0;
    if ((sync2_r == cand_r) && (deb_cnt_r >= CNT_MAX)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
    if (load_s && (cand_r != stable_r)) begin
      set_s = 1'b1;
    end else begin
      set_s = 1'b0;
    end
    if (io_rd && (io_addr == ADDR_STATUS)) begin
      clr_s = 1'b1;
    end else begin
      clr_s = 1'b0;
    end
  end

  // Synchroniser and debounce window; any difference at sync2 restarts the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r   <= 24'h000000;
      sync2_r   <= 24'h000000;
      cand_r    <= 24'h000000;
      stable_r  <= 24'h000000;
      deb_cnt_r <= CNT_ZERO;
    end else begin
      sync1_r <= switch_in;
      sync2_r <= sync1_r;
      if (sync2_r != cand_r) begin
        cand_r    <= sync2_r;
        deb_cnt_r <= CNT_ZERO;
      end else if (deb_cnt_r < CNT_MAX) begin
        deb_cnt_r <= deb_cnt_r + CNT_ONE;
      end else begin
        stable_r <= cand_r;
      end
    end
  end

  // Sticky change flag (a set beats a same-edge clear) and wrapping change counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed_r <= 1'b0;
      chg_cnt_r <= 16'h0000;
    end else begin
      if (set_s) begin
        changed_r <= 1'b1;
        chg_cnt_r <= chg_cnt_r + 16'h0001;
      end else if (clr_s) begin
        changed_r <= 1'b0;
      end
    end
  end

  // Read port, combinational from the address and the registers
  always_comb begin
    io_rdata = 32'h00000000;
    case (io_addr)
      ADDR_DATA:   io_rdata = {16'h0000, stable_r[15:0]};
      ADDR_MODE:   io_rdata = {29'h00000000, stable_r[23:21]};
      ADDR_STATUS: io_rdata = {31'h00000000, changed_r};
      ADDR_COUNT:  io_rdata = {16'h0000, chg_cnt_r};
      default:     io_rdata = 32'h00000000;
    endcase
  end

  assign sw_mode    = stable_r[23:21];
  assign sw_changed = changed_r;

endmodule

// File: tb/tb_switch_io.sv
// Bench for switch_io: directed scenarios plus randomized traffic checked
// against a window-based model of the debounce and status registers.
module tb_switch_io;

  localparam int D  = 4;
  localparam int HN = D + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] switch_in;
  logic        io_rd;
  logic [1:0]  io_addr;
  logic [31:0] io_rdata;
  logic [2:0]  sw_mode;
  logic        sw_changed;

  int checks = 0;
  int errors = 0;

  // Model: raw value seen before each of the last HN edges (index 0 = newest)
  logic [23:0] hist [HN];
  logic [23:0] m_stable;
  logic        m_changed;
  logic [15:0] m_cnt;

  switch_io #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .switch_in  (switch_in),
    .io_rd      (io_rd),
    .io_addr    (io_addr),
    .io_rdata   (io_rdata),
    .sw_mode    (sw_mode),
    .sw_changed (sw_changed)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < HN; k++) hist[k] = 24'h000000;
    m_stable  = 24'h000000;
    m_changed = 1'b0;
    m_cnt     = 16'h0000;
  endtask

  // The snapshot takes a value once the raw input was identical for D+1
  // consecutive edges, seen two edges late through the synchroniser.
  function automatic logic window_steady();
    for (int k = 3; k < HN; k++) begin
      if (hist[k] != hist[2]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    logic set;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = HN - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = switch_in;
      set = 1'b0;
      if (window_steady() && (hist[2] != m_stable)) begin
        m_stable = hist[2];
        m_cnt    = m_cnt + 16'h0001;
        set      = 1'b1;
      end
      if (set) m_changed = 1'b1;
      else if (io_rd && io_addr == 2'd2) m_changed = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {16'h0000, m_stable[15:0]};
      2'd1:    return {29'h0, m_stable[23:21]};
      2'd2:    return {31'h0, m_changed};
      default: return {16'h0000, m_cnt};
    endcase
  endfunction

  // One clock edge; inputs are held, model advances on the same pre-edge inputs
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; switch_in = 24'hC0F000; io_rd = 1'b0; io_addr = 2'd0;
    model_reset();
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      for (int a = 0; a < 4; a++) begin
        io_addr = 2'(a); #1;
        checks++;
        if (io_rdata !== 32'h0) begin
          errors++; $display("FAIL reset_read addr%0d: got %h expected 00000000", a, io_rdata);
        end
      end
      checks++;
      if (sw_mode !== 3'd0 || sw_changed !== 1'b0) begin
        errors++; $display("FAIL reset_outs: got mode %0d chg %b expected 0 0", sw_mode, sw_changed);
      end
      tick(1);
    end
    rst = 1'b0;
    tick(6);
    io_addr = 2'd0; #1;
    checks++;
    if (io_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_edge6: got %h expected 00000000", io_rdata);
    end
    tick(1);
    io_addr = 2'd0; #1;
    checks++;
    if (io_rdata !== 32'h0000F000) begin
      errors++; $display("FAIL reset_addr0: got %h expected 0000f000", io_rdata);
    end
    io_addr = 2'd1; #1;
    checks++;
    if (io_rdata !== 32'h6 || sw_mode !== 3'd6) begin
      errors++; $display("FAIL reset_addr1: got %h mode %0d expected 6", io_rdata, sw_mode);
    end
    io_addr = 2'd3; #1;
    checks++;
    if (io_rdata !== 32'h1 || sw_changed !== 1'b1) begin
      errors++; $display("FAIL reset_count: got %h chg %b expected 1 1", io_rdata, sw_changed);
    end
    tick(1);
  endtask

  task automatic test_latency();
    switch_in = 24'h200001;
    tick(6);
    io_addr = 2'd0; #1;
    checks++;
    if (io_rdata !== 32'h0000F000) begin
      errors++; $display("FAIL latency_edge6_addr0: got %h expected 0000f000", io_rdata);
    end
    io_addr = 2'd1; #1;
    checks++;
    if (io_rdata !== 32'h6) begin
      errors++; $display("FAIL latency_edge6_addr1: got %h expected 6", io_rdata);
    end
    tick(1);
    io_addr = 2'd0; #1;
    checks++;
    if (io_rdata !== 32'h1) begin
      errors++; $display("FAIL latency_edge7_addr0: got %h expected 1", io_rdata);
    end
    io_addr = 2'd1; #1;
    checks++;
    if (io_rdata !== 32'h1 || sw_mode !== 3'd1) begin
      errors++; $display("FAIL latency_edge7_addr1: got %h mode %0d expected 1", io_rdata, sw_mode);
    end
    io_addr = 2'd3; #1;
    checks++;
    if (io_rdata !== 32'h2) begin
      errors++; $display("FAIL latency_count: got %h expected 2", io_rdata);
    end
  endtask

  task automatic test_clear_on_read();
    io_addr = 2'd2; io_rd = 1'b1; #1;
    checks++;
    if (io_rdata !== 32'h1) begin
      errors++; $display("FAIL clear_same_cycle: got %h expected 1", io_rdata);
    end
    tick(1);
    io_rd = 1'b0; #1;
    checks++;
    if (io_rdata !== 32'h0 || sw_changed !== 1'b0) begin
      errors++; $display("FAIL clear_next_cycle: got %h chg %b expected 0 0", io_rdata, sw_changed);
    end
  endtask

  task automatic test_glitch();
    switch_in = 24'h000000;
    tick(8);
    io_addr = 2'd2; io_rd = 1'b1;
    tick(1);
    io_rd = 1'b0;
    switch_in = 24'h000001;
    tick(3);
    switch_in = 24'h000000;
    tick(10);
    io_addr = 2'd0; #1;
    checks++;
    if (io_rdata !== 32'h0) begin
      errors++; $display("FAIL glitch_addr0: got %h expected 0", io_rdata);
    end
    io_addr = 2'd2; #1;
    checks++;
    if (io_rdata !== 32'h0) begin
      errors++; $display("FAIL glitch_changed: got %h expected 0", io_rdata);
    end
    io_addr = 2'd3; #1;
    checks++;
    if (io_rdata !== 32'h3) begin
      errors++; $display("FAIL glitch_count: got %h expected 3", io_rdata);
    end
  endtask

  task automatic test_set_wins();
    switch_in = 24'hA51234;
    tick(6);
    io_addr = 2'd2; io_rd = 1'b1; #1;
    checks++;
    if (io_rdata !== 32'h0) begin
      errors++; $display("FAIL setwins_pre: got %h expected 0", io_rdata);
    end
    tick(1);
    io_rd = 1'b0; #1;
    checks++;
    if (io_rdata !== 32'h1 || sw_changed !== 1'b1) begin
      errors++; $display("FAIL setwins_flag: got %h chg %b expected 1 1", io_rdata, sw_changed);
    end
    io_addr = 2'd0; #1;
    checks++;
    if (io_rdata !== 32'h1234) begin
      errors++; $display("FAIL setwins_addr0: got %h expected 1234", io_rdata);
    end
  endtask

  task automatic test_wrap();
    force dut.chg_cnt_r = 16'hFFFF;
    #1;
    release dut.chg_cnt_r;
    m_cnt = 16'hFFFF;
    io_addr = 2'd3; #1;
    checks++;
    if (io_rdata !== 32'h0000FFFF) begin
      errors++; $display("FAIL wrap_preload: got %h expected 0000ffff", io_rdata);
    end
    io_addr = 2'd2; io_rd = 1'b1;
    tick(1);
    io_rd = 1'b0;
    switch_in = 24'h3C0F0F;
    tick(7);
    io_addr = 2'd3; #1;
    checks++;
    if (io_rdata !== 32'h0) begin
      errors++; $display("FAIL wrap_count: got %h expected 0", io_rdata);
    end
    io_addr = 2'd2; #1;
    checks++;
    if (io_rdata !== 32'h1) begin
      errors++; $display("FAIL wrap_changed: got %h expected 1", io_rdata);
    end
  endtask

  task automatic test_async_reset();
    switch_in = 24'h815A5A;
    io_addr = 2'd0;
    tick(5);
    checks++;
    if (dut.deb_cnt_r !== 3'd2 || dut.cand_r !== 24'h815A5A) begin
      errors++; $display("FAIL arst_window: got cnt %0d cand %h expected 2 815a5a", dut.deb_cnt_r, dut.cand_r);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut.cand_r !== 24'h0 || dut.deb_cnt_r !== 3'd0) begin
      errors++; $display("FAIL arst_immediate: got cand %h cnt %0d expected 0 0", dut.cand_r, dut.deb_cnt_r);
    end
    checks++;
    if (io_rdata !== 32'h0 || sw_mode !== 3'd0 || sw_changed !== 1'b0) begin
      errors++; $display("FAIL arst_outs: got %h mode %0d chg %b expected 0 0 0", io_rdata, sw_mode, sw_changed);
    end
    @(negedge clk);
    tick(1);
    rst = 1'b0;
    tick(6);
    #1;
    checks++;
    if (io_rdata !== 32'h0) begin
      errors++; $display("FAIL arst_edge6: got %h expected 0", io_rdata);
    end
    tick(1);
    #1;
    checks++;
    if (io_rdata !== 32'h5A5A) begin
      errors++; $display("FAIL arst_edge7_addr0: got %h expected 5a5a", io_rdata);
    end
    io_addr = 2'd1; #1;
    checks++;
    if (io_rdata !== 32'h4) begin
      errors++; $display("FAIL arst_edge7_addr1: got %h expected 4", io_rdata);
    end
    io_addr = 2'd3; #1;
    checks++;
    if (io_rdata !== 32'h1) begin
      errors++; $display("FAIL arst_count: got %h expected 1", io_rdata);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) switch_in = 24'($urandom);
      io_rd   = ($urandom_range(3) == 0);
      io_addr = 2'($urandom_range(3));
      #1;
      checks++;
      if (io_rdata !== exp_rdata(io_addr)) begin
        errors++; $display("FAIL random_read c%0d addr%0d: got %h expected %h", c, io_addr, io_rdata, exp_rdata(io_addr));
      end
      checks++;
      if (sw_mode !== m_stable[23:21] || sw_changed !== m_changed) begin
        errors++; $display("FAIL random_outs c%0d: got mode %0d chg %b expected %0d %b", c, sw_mode, sw_changed, m_stable[23:21], m_changed);
      end
      tick(1);
    end
    io_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_clear_on_read();
    test_glitch();
    test_set_wins();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
